// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the pwm_fade level generator and its neighbours.
package pwm_fade_pkg;

    // Default level width; the downstream pwm instance uses the same value.
    localparam int PW_BITS_DEF   = 8;
    localparam int RATE_BITS_DEF = 16;

    // Ramp controller state, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_fade_if.sv
// Request/level bundle between a controller and the pwm_fade ramp generator.
//
// Handshake: a request is taken on a rising clk edge where target_valid and
// target_ready are both high. target/step/rate are only sampled on that edge.
// target_ready is high exactly while the generator is idle; a target_valid
// seen while target_ready is low is dropped, not queued.
interface pwm_fade_if #(
    parameter int PW_BITS   = 8,
    parameter int RATE_BITS = 16
);
    import pwm_fade_pkg::*;

    logic [PW_BITS-1:0]   target;
    logic [PW_BITS-1:0]   step;
    logic [RATE_BITS-1:0] rate;
    logic                 target_valid;
    logic                 target_ready;
    logic                 abort;
    logic [PW_BITS-1:0]   pulse_width;
    logic                 busy;
    logic                 done;
    state_t               dbg_state;

    modport master (
        output target, step, rate, target_valid, abort,
        input  target_ready, pulse_width, busy, done, dbg_state
    );

    modport slave (
        input  target, step, rate, target_valid, abort,
        output target_ready, pulse_width, busy, done, dbg_state
    );

endinterface

// File: rtl/pwm_fade_tick_gen.sv
// Programmable prescaler: emits a one-cycle tick every rate+1 enabled cycles.
module pwm_fade_tick_gen #(
    parameter int RATE_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [RATE_BITS-1:0] rate,
    output logic                 tick
);

    logic [RATE_BITS-1:0] r_count;
    logic                 w_hit;

    assign w_hit = (r_count == rate);
    assign tick  = enable && w_hit;

    // Count enabled cycles, wrapping to 0 on the tick; clear wins over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (w_hit) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_fade.sv
// Level ramp generator feeding pwm.pulse_width: walks the output level toward
// an accepted target in clamped steps, one step per prescaler tick.
module pwm_fade
    import pwm_fade_pkg::*;
#(
    parameter int PW_BITS   = PW_BITS_DEF,
    parameter int RATE_BITS = RATE_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    pwm_fade_if.slave  bus
);

    state_t               r_state;
    logic [PW_BITS-1:0]   r_pulse_width;
    logic [PW_BITS-1:0]   r_target_q;
    logic [PW_BITS-1:0]   r_step_q;
    logic [RATE_BITS-1:0] r_rate_q;
    logic                 r_done;

    logic                 w_ready;
    logic                 w_ramp;
    logic                 w_accept;
    logic                 w_abort;
    logic                 w_tick;
    logic [PW_BITS-1:0]   w_s;
    logic [PW_BITS:0]     w_diff;
    logic                 w_land;

    assign w_ready  = (r_state == IDLE);
    assign w_ramp   = !w_ready;
    assign w_accept = bus.target_valid && w_ready;
    assign w_abort  = bus.abort && w_ramp;

    // A zero step would never arrive, so it behaves as a step of one.
    assign w_s = (r_step_q == '0) ? {{(PW_BITS-1){1'b0}}, 1'b1} : r_step_q;

    // One extra bit keeps the distance exact; the ramp direction fixes its sign.
    assign w_diff = (r_state == RAMP_UP) ? ({1'b0, r_target_q} - {1'b0, r_pulse_width})
                                         : ({1'b0, r_pulse_width} - {1'b0, r_target_q});
    assign w_land = (w_diff <= {1'b0, w_s});

    // Abort suppresses a coincident tick so the level cannot move on that edge.
    pwm_fade_tick_gen #(
        .RATE_BITS (RATE_BITS)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_accept || w_abort),
        .enable (w_ramp && !bus.abort),
        .rate   (r_rate_q),
        .tick   (w_tick)
    );

    // Ramp FSM: accept in IDLE, step on ticks, land or abort back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pulse_width <= '0;
            r_target_q    <= '0;
            r_step_q      <= '0;
            r_rate_q      <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.target_valid) begin
                        r_target_q <= bus.target;
                        r_step_q   <= bus.step;
                        r_rate_q   <= bus.rate;
                        if (bus.target > r_pulse_width) begin
                            r_state <= RAMP_UP;
                        end else if (bus.target < r_pulse_width) begin
                            r_state <= RAMP_DOWN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        if (w_land) begin
                            r_pulse_width <= r_target_q;
                            r_state       <= IDLE;
                            r_done        <= 1'b1;
                        end else if (r_state == RAMP_UP) begin
                            r_pulse_width <= r_pulse_width + w_s;
                        end else begin
                            r_pulse_width <= r_pulse_width - w_s;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.target_ready = w_ready;
    assign bus.busy         = w_ramp;
    assign bus.done         = r_done;
    assign bus.pulse_width  = r_pulse_width;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_pwm_fade.sv
// Bench for pwm_fade: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a trajectory model.
module tb_pwm_fade;
    import pwm_fade_pkg::*;

    localparam int PW = 8;
    localparam int RB = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pwm_fade_if #(.PW_BITS(PW), .RATE_BITS(RB)) bus();

    pwm_fade #(.PW_BITS(PW), .RATE_BITS(RB)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // On accept the whole future trajectory is laid out as a list of
    // post-edge levels: rate idle cycles, then one clamped step, repeated
    // until the target is hit. Bit 8 marks the landing entry.
    logic [8:0] exp_q[$];
    logic [7:0] m_level = '0;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    logic [8:0] m_e;

    function automatic void plan_ramp(input int from, input int to, input int st, input int rt);
        int lvl;
        int s;
        int d;
        logic last;
        lvl = from;
        s = (st == 0) ? 1 : st;
        last = 1'b0;
        while (!last) begin
            for (int i = 0; i < rt; i++) exp_q.push_back({1'b0, lvl[7:0]});
            d = (to > lvl) ? (to - lvl) : (lvl - to);
            if (d <= s) begin
                lvl = to;
                last = 1'b1;
            end else begin
                lvl = (to > lvl) ? (lvl + s) : (lvl - s);
            end
            exp_q.push_back({last, lvl[7:0]});
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level = '0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            exp_q.delete();
        end else if (m_busy) begin
            m_done = 1'b0;
            if (bus.abort) begin
                m_busy = 1'b0;
                exp_q.delete();
            end else if (exp_q.size() > 0) begin
                m_e     = exp_q.pop_front();
                m_level = m_e[7:0];
                m_done  = m_e[8];
                if (m_e[8]) m_busy = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (bus.target_valid) begin
                if (bus.target == m_level) begin
                    m_done = 1'b1;
                end else begin
                    plan_ramp(int'(m_level), int'(bus.target), int'(bus.step), int'(bus.rate));
                    m_busy = 1'b1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("pulse_width", int'(bus.pulse_width), int'(m_level));
        check("done", int'(bus.done), int'(m_done));
        check("busy", int'(bus.busy), int'(m_busy));
        check("target_ready", int'(bus.target_ready), int'(!m_busy));
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [15:0] r);
        bus.target       = t;
        bus.step         = s;
        bus.rate         = r;
        bus.target_valid = 1'b1;
        @(negedge clk);
        bus.target_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int k;
        k = 0;
        while (bus.busy && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_timeout", int'(bus.busy), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        bus.target       = '0;
        bus.step         = '0;
        bus.rate         = '0;
        bus.target_valid = 1'b0;
        bus.abort        = 1'b0;

        // Reset held with a pending request: nothing may be accepted.
        #1 rst_n = 1'b0;
        bus.target       = 8'd50;
        bus.step         = 8'd1;
        bus.target_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_pw", int'(bus.pulse_width), 0);
            check("rst_ready", int'(bus.target_ready), 1);
        end
        rst_n = 1'b1;
        bus.target_valid = 1'b0;
        @(negedge clk);
        check("post_rst_pw", int'(bus.pulse_width), 0);

        // Ramp up 0->10, step 1, rate 3: landing at edge 40.
        send(8'd10, 8'd1, 16'd3);
        repeat (39) @(negedge clk);
        check("up_e39_pw", int'(bus.pulse_width), 9);
        check("up_e39_done", int'(bus.done), 0);
        @(negedge clk);
        check("up_e40_pw", int'(bus.pulse_width), 10);
        check("up_e40_done", int'(bus.done), 1);
        check("up_e40_ready", int'(bus.target_ready), 1);
        @(negedge clk);
        check("up_done_clear", int'(bus.done), 0);

        // Clamp down 250->3, step 100, rate 0.
        send(8'd250, 8'd255, 16'd0);
        @(negedge clk);
        check("to250", int'(bus.pulse_width), 250);
        send(8'd3, 8'd100, 16'd0);
        @(negedge clk);
        check("dn_e1", int'(bus.pulse_width), 150);
        @(negedge clk);
        check("dn_e2", int'(bus.pulse_width), 50);
        @(negedge clk);
        check("dn_e3", int'(bus.pulse_width), 3);
        check("dn_e3_done", int'(bus.done), 1);

        // Top saturation 200->255, then zero step 5->7.
        send(8'd200, 8'd255, 16'd0);
        @(negedge clk);
        send(8'd255, 8'd100, 16'd0);
        @(negedge clk);
        check("sat_e1", int'(bus.pulse_width), 255);
        check("sat_done", int'(bus.done), 1);
        send(8'd5, 8'd255, 16'd0);
        @(negedge clk);
        send(8'd7, 8'd0, 16'd0);
        @(negedge clk);
        check("step0_e1", int'(bus.pulse_width), 6);
        @(negedge clk);
        check("step0_e2", int'(bus.pulse_width), 7);
        check("step0_done", int'(bus.done), 1);

        // Abort at 40, then a new request down to 20.
        send(8'd0, 8'd255, 16'd0);
        @(negedge clk);
        send(8'd100, 8'd1, 16'd0);
        k = 0;
        while (bus.pulse_width != 8'd40 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach40", int'(bus.pulse_width), 40);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_hold", int'(bus.pulse_width), 40);
        check("abort_no_done", int'(bus.done), 0);
        check("abort_idle", int'(bus.busy), 0);
        send(8'd20, 8'd1, 16'd0);
        repeat (19) @(negedge clk);
        check("after_abort_e19", int'(bus.pulse_width), 21);
        @(negedge clk);
        check("after_abort_e20", int'(bus.pulse_width), 20);
        check("after_abort_done", int'(bus.done), 1);

        // Equal target: zero-length ramp.
        send(8'd20, 8'd5, 16'd0);
        check("eq_done", int'(bus.done), 1);
        check("eq_busy", int'(bus.busy), 0);
        @(negedge clk);
        check("eq_done_clear", int'(bus.done), 0);

        // Requests during a ramp are ignored.
        send(8'd60, 8'd1, 16'd1);
        bus.target       = 8'd0;
        bus.target_valid = 1'b1;
        repeat (10) @(negedge clk);
        bus.target_valid = 1'b0;
        wait_idle(200);
        check("ignore_pw", int'(bus.pulse_width), 60);
        check("ignore_done", int'(bus.done), 1);

        // Asynchronous reset mid-ramp.
        send(8'd200, 8'd1, 16'd0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pw", int'(bus.pulse_width), 0);
        check("midrst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized phase, checked by the compare process every cycle.
        for (int c = 0; c < 3000; c++) begin
            bus.target_valid = ($urandom_range(0, 2) == 0);
            bus.target       = ($urandom_range(0, 7) == 0) ? m_level : 8'($urandom_range(0, 255));
            bus.step         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                           : 8'($urandom_range(0, 80));
            bus.rate         = 16'($urandom_range(0, 3));
            bus.abort        = ($urandom_range(0, 60) == 0);
            @(negedge clk);
        end
        bus.target_valid = 1'b0;
        bus.abort        = 1'b0;
        wait_idle(1200);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
